// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD adder/subtractor, one digit per clock
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  acc;
  logic          sub_q;
  logic          carry;
  logic          bad;

  logic [3:0]    a_d;
  logic [3:0]    b_d;
  logic [3:0]    bp;
  logic [4:0]    t;
  logic [3:0]    digit;
  logic          carry_nxt;
  logic          bad_nxt;
  logic [W-1:0]  acc_nxt;

  // Operand registers shift right each step, so the current digit is always the low nibble.
  always_comb begin
    a_d       = a_q[3:0];
    b_d       = b_q[3:0];
    bp        = sub_q ? (4'd9 - b_d) : b_d;
    t         = {1'b0, a_d} + {1'b0, bp} + {4'd0, carry};
    digit     = t[3:0];
    carry_nxt = 1'b0;
    if (t > 5'd9) begin
      digit     = t[3:0] + 4'd6;
      carry_nxt = 1'b1;
    end
    bad_nxt   = bad | (a_d > 4'd9) | (b_d > 4'd9);
  end

  generate
    if (DIGITS == 1) begin : g_one
      assign acc_nxt = digit;
    end else begin : g_multi
      assign acc_nxt = {digit, acc[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      sub_q   <= 1'b0;
      carry   <= 1'b0;
      bad     <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            idx   <= '0;
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            carry <= sub ? 1'b1 : cin;
            bad   <= 1'b0;
          end
        end
        RUN: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          acc   <= acc_nxt;
          carry <= carry_nxt;
          bad   <= bad_nxt;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            state   <= DONE;
            sum     <= acc_nxt;
            cout    <= carry_nxt;
            invalid <= bad_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - directed and swept checks of bcd_serial_addsub at 1, 4 and 8 digits
module tb_bcd_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        sub_in = 1'b0;
  logic        cin_in = 1'b0;
  logic [2:0]  start_v = '0;

  logic [3:0]  sum1;
  logic [15:0] sum4;
  logic [31:0] sum8;
  logic [2:0]  cout_v, busy_v, done_v, inv_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_in), .a(a_in[3:0]), .b(b_in[3:0]),
    .cin(cin_in), .sum(sum1), .cout(cout_v[0]), .busy(busy_v[0]), .done(done_v[0]), .invalid(inv_v[0])
  );
  bcd_serial_addsub #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_in), .a(a_in[15:0]), .b(b_in[15:0]),
    .cin(cin_in), .sum(sum4), .cout(cout_v[1]), .busy(busy_v[1]), .done(done_v[1]), .invalid(inv_v[1])
  );
  bcd_serial_addsub #(.DIGITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_in), .a(a_in), .b(b_in),
    .cin(cin_in), .sum(sum8), .cout(cout_v[2]), .busy(busy_v[2]), .done(done_v[2]), .invalid(inv_v[2])
  );

  logic [1:0]  sel = 2'd1;
  logic [31:0] c_sum;
  logic        c_cout, c_busy, c_done, c_inv;

  always_comb begin
    case (sel)
      2'd0:    c_sum = {28'd0, sum1};
      2'd1:    c_sum = {16'd0, sum4};
      default: c_sum = sum8;
    endcase
    c_cout = cout_v[sel];
    c_busy = busy_v[sel];
    c_done = done_v[sel];
    c_inv  = inv_v[sel];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [31:0] x, input int nd);
    longint v = 0;
    for (int i = nd - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [31:0] int2bcd(input longint v, input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] rbcd(input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  function automatic void model(input int nd, input logic [31:0] av, input logic [31:0] bv,
                                input logic s, input logic c,
                                output logic [31:0] rs, output logic rc);
    longint ai = bcd2int(av, nd);
    longint bi = bcd2int(bv, nd);
    longint m = 1;
    longint r;
    for (int i = 0; i < nd; i++) m = m * 10;
    if (!s) begin
      r  = ai + bi + longint'(c);
      rc = (r >= m);
      if (rc) r = r - m;
    end else if (ai >= bi) begin
      rc = 1'b1;
      r  = ai - bi;
    end else begin
      rc = 1'b0;
      r  = m - (bi - ai);
    end
    rs = int2bcd(r, nd);
  endfunction

  // Inputs are scrambled right after the start edge to prove the operands were latched.
  task automatic op(input logic [1:0] d, input logic [31:0] av, input logic [31:0] bv,
                    input logic s, input logic c,
                    output logic [31:0] rs, output logic rc, output logic ri, output int lat);
    logic [31:0] prev;
    sel = d;
    @(negedge clk);
    prev    = c_sum;
    a_in    = av;
    b_in    = bv;
    sub_in  = s;
    cin_in  = c;
    start_v = '0;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    a_in    = $urandom;
    b_in    = $urandom;
    sub_in  = ~s;
    cin_in  = ~c;
    check("busy_after_start", c_busy, 1'b1);
    check("sum_hold_in_run", c_sum, prev);
    lat = 0;
    while (!c_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = c_sum;
    rc = c_cout;
    ri = c_inv;
    @(posedge clk); #1;
    check("done_one_cycle", c_done, 1'b0);
    check("idle_after_done", c_busy, 1'b0);
  endtask

  task automatic do4(input string tag, input logic [15:0] av, input logic [15:0] bv,
                     input logic s, input logic c,
                     input logic [15:0] es, input logic ec, input logic ei);
    logic [31:0] rs;
    logic        rc, ri;
    int          lat;
    op(2'd1, {16'd0, av}, {16'd0, bv}, s, c, rs, rc, ri, lat);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, rs, {16'd0, es});
    check({tag, "_cout"}, rc, ec);
    check({tag, "_inv"}, ri, ei);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] rs, es, av, bv;
    logic        rc, ri, ec, cc;
    logic [14:0] mask;
    logic        seen;
    int          lat, nd;
    logic [1:0]  dd;

    repeat (3) @(negedge clk);
    check("rst_sum", sum4, 16'h0);
    check("rst_cout", cout_v[1], 1'b0);
    check("rst_busy", busy_v[1], 1'b0);
    check("rst_done", done_v[1], 1'b0);
    check("rst_inv", inv_v[1], 1'b0);
    rst_n = 1'b1;

    do4("add_corr",   16'h0066, 16'h0066, 1'b0, 1'b0, 16'h0132, 1'b0, 1'b0);
    do4("ripple",     16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do4("ripple_cin", 16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    do4("sub_ge",     16'h0100, 16'h0001, 1'b1, 1'b0, 16'h0099, 1'b1, 1'b0);
    do4("sub_lt",     16'h0001, 16'h0002, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0);
    do4("sub_cin_ign",16'h0500, 16'h0250, 1'b1, 1'b1, 16'h0250, 1'b1, 1'b0);
    do4("invalid",    16'h000A, 16'h0001, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b1);
    do4("valid_after",16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    // start held for ten edges: second op accepted at the first IDLE edge
    sel = 2'd1;
    @(negedge clk);
    a_in = 32'h0001; b_in = 32'h0002; sub_in = 1'b0; cin_in = 1'b0;
    start_v = 3'b010;
    mask = '0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (k == 9) start_v = '0;
      if (c_done) mask[k] = 1'b1;
    end
    check("held_start_done_at", mask, 15'h0410);
    check("held_start_sum", c_sum, 32'h0003);

    do4("pre_reset", 16'h5000, 16'h6000, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0);

    // reset pulsed in the middle of RUN
    @(negedge clk);
    a_in = 32'h0123; b_in = 32'h0456; start_v = 3'b010;
    @(posedge clk); #1;
    start_v = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_before_rst", c_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", c_busy, 1'b0);
    check("mid_rst_sum", c_sum, 32'h0);
    check("mid_rst_cout", c_cout, 1'b0);
    check("mid_rst_done", c_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (c_done || c_busy) seen = 1'b1;
    end
    check("no_done_after_abort", seen, 1'b0);

    // parameter sweep at 1 and 8 digits against the decimal model
    for (int k = 0; k < 2; k++) begin
      dd = (k == 0) ? 2'd0 : 2'd2;
      nd = (k == 0) ? 1 : 8;
      if (k == 0) begin
        op(dd, 32'h9, 32'h9, 1'b0, 1'b1, rs, rc, ri, lat);
        check("d1_max_sum", rs, 32'h9);
        check("d1_max_cout", rc, 1'b1);
        op(dd, 32'h0, 32'h1, 1'b1, 1'b0, rs, rc, ri, lat);
        check("d1_borrow_sum", rs, 32'h9);
        check("d1_borrow_cout", rc, 1'b0);
      end
      for (int m = 0; m < 2; m++) begin
        for (int n = 0; n < 6; n++) begin
          av = rbcd(nd);
          bv = rbcd(nd);
          cc = 1'($urandom_range(1, 0));
          model(nd, av, bv, m[0], cc, es, ec);
          op(dd, av, bv, m[0], cc, rs, rc, ri, lat);
          check("sweep_lat", lat, nd);
          check("sweep_sum", rs, es);
          check("sweep_cout", rc, ec);
          check("sweep_inv", ri, 1'b0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Digit-serial, parametrised BCD adder/subtractor for multi-digit packed-BCD operands. It accepts a start request, processes one decimal digit per clock from least-significant digit upward, and reports a registered result with a one-cycle done pulse. It is the sequential, N-digit successor to the single-digit combinational BCD adder and feeds the decimal datapath and display logic.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range is 1 to 16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  mode: 0 computes a+b+cin; 1 computes a−b.
- a  input  4*DIGITS  packed BCD operand; digit i is a[4i+3:4i].
- b  input  4*DIGITS  packed BCD operand.
- cin  input  1  decimal carry-in; ignored when sub=1.
- sum  output  4*DIGITS  packed BCD result, registered.
- cout  output  1  decimal carry-out (add mode); no-borrow flag (sub mode).
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse marking sum/cout valid.
- invalid  output  1  high when any latched a or b digit is greater than 9; registered with the result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start=1. At that edge:
  - a, b, sub and cin are latched.
  - Digit index is set to 0.
  - Carry is initialised to cin (add mode) or 1 (sub mode).
- Operand b' per digit: b_i when sub=0; nines-complement (9 − b_i) mod 16 when sub=1.
- RUN, one digit per edge:
  - t = a_i + b'_i + carry, using a 5-bit intermediate.
  - If t > 9: digit = (t + 6) mod 16 and carry = 1.
  - Otherwise: digit = t and carry = 0.
  - The digit is shifted into an internal result register; the index increments.
- RUN → DONE on the edge that processes digit DIGITS−1.
  - At the same edge, sum, cout (final carry) and invalid are loaded.
- DONE → IDLE unconditionally after one cycle.
- Subtract mode:
  - cout=1 means a ≥ b, and sum = a − b.
  - cout=0 means a < b, and sum is the tens-complement (10^DIGITS − (b − a)).
- start while busy=1, including the DONE cycle, is ignored; it is not queued.
- Input changes on a, b, sub or cin after the start edge do not affect the operation in flight.
- When invalid=1, sum and cout follow the exact digit rule above. Only the value of invalid is checked; the decimal meaning of sum is unspecified.

## Timing
- Reset (asynchronous, any time, including mid-RUN):
  - State returns to IDLE immediately.
  - sum = 0, cout = 0, busy = 0, done = 0, invalid = 0.
  - No done pulse is produced for the aborted operation.
- Start accepted at edge E0.
  - busy is high from after E0 until after edge E(DIGITS+1).
  - done is high for exactly the cycle between E(DIGITS) and E(DIGITS+1).
- Latency: start edge to done = DIGITS cycles. Throughput: one operation per DIGITS+2 cycles.
  - The earliest next accepted start is at E(DIGITS+2), the first IDLE cycle.
- sum, cout and invalid hold their previous values during RUN.
  - They change only at the edge that raises done.
  - They remain stable until the next operation's done edge or a reset.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
All scenarios use DIGITS=4 unless noted.
- Add with correction: a=0x0066, b=0x0066, cin=0, sub=0 → done 4 cycles after start, sum=0x0132, cout=0, invalid=0.
- Full ripple: a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1. Repeat with cin=1 and b=0x0000 → the same result.
- Subtract:
  - a=0x0100, b=0x0001, sub=1 → sum=0x0099, cout=1.
  - a=0x0001, b=0x0002, sub=1 → sum=0x9999, cout=0.
- Invalid digit: a=0x000A, b=0x0001 → invalid=1 with done. A following valid operation → invalid=0.
- Protocol:
  - start held high for 10 cycles → exactly two operations, with done at cycles 4 and 10.
  - Operands changed during RUN → the result reflects the latched values.
  - rst_n pulsed low in the middle of RUN → busy=0 immediately, no done pulse, sum=0.
- Parameter sweep at DIGITS=1 and DIGITS=8, random valid BCD operands in both modes → result matches a decimal reference model, and latency equals DIGITS.
